coherence_ctrl: RTL and testbench

COHERENCE_CTRL -- requirements
Module: coherence_ctrl

---
 rtl/coherence_ctrl.sv | 165 ++++++++++++++++
 tb/tb_coherence_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/coherence_ctrl.sv
// Two-core snooping coherence controller.
// One transaction at a time: IDLE grants a single core, snoops the other core
// when the request is a data read or an ownership request, then serves the
// word from the dirty peer cache or from memory. Data requests take priority
// over instruction fetches, and each class has its own round-robin pointer.
// Outputs are decoded combinationally from the registered state. A
// transaction is abandoned the moment nRST falls, because the state register
// resets asynchronously.
module coherence_ctrl (
   input  logic             CLK,
   input  logic             nRST,
   input  logic [1:0]       iREN,
   input  logic [1:0][31:0] iaddr,
   input  logic [1:0]       dREN,
   input  logic [1:0]       dWEN,
   input  logic [1:0][31:0] daddr,
   input  logic [1:0][31:0] dstore,
   input  logic [1:0]       cctrans,
   input  logic [1:0]       ccwrite,
   output logic [1:0]       iwait,
   output logic [1:0]       dwait,
   output logic [1:0][31:0] iload,
   output logic [1:0][31:0] dload,
   output logic [1:0]       ccwait,
   output logic [1:0]       ccinv,
   output logic [1:0][31:0] ccsnoopaddr,
   output logic             ramREN,
   output logic             ramWEN,
   output logic [31:0]      ramaddr,
   output logic [31:0]      ramstore,
   input  logic [31:0]      ramload,
   input  logic             ram_ready
);

   typedef enum logic [3:0] {
      IDLE, SNOOP, C2C0, C2C1, MEM0, MEM1, UPGR, DWR, IFETCH
   } state_t;

   state_t     state_q, state_d;
   logic       r_q, r_d;         // requester latched at grant
   logic       inv_q, inv_d;     // invalidate the snooper for this transaction
   logic       dptr_q, dptr_d;   // round-robin pointer, data class
   logic       iptr_q, iptr_d;   // round-robin pointer, instruction class
   logic       s_w;              // snooper is always the other core
   logic [1:0] dreq_w;
   logic       live_w;           // requester still holds its data request

   assign s_w    = ~r_q;
   assign dreq_w = dREN | dWEN | cctrans;
   assign live_w = dreq_w[r_q];

   // State, grant and pointer registers; reset abandons any transaction.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         r_q     <= 1'b0;
         inv_q   <= 1'b0;
         dptr_q  <= 1'b0;
         iptr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         inv_q   <= inv_d;
         dptr_q  <= dptr_d;
         iptr_q  <= iptr_d;
      end
   end

   // Arbitration, next state and all outputs for the current state.
   always_comb begin
      state_d     = state_q;
      r_d         = r_q;
      inv_d       = inv_q;
      dptr_d      = dptr_q;
      iptr_d      = iptr_q;
      iwait       = 2'b11;
      dwait       = 2'b11;
      iload       = '0;
      dload       = '0;
      ccwait      = 2'b00;
      ccinv       = 2'b00;
      ccsnoopaddr = '0;
      ramREN      = 1'b0;
      ramWEN      = 1'b0;
      ramaddr     = '0;
      ramstore    = '0;

      // The snoop command stays up from SNOOP until the return to IDLE, so
      // the peer cache sees a constant request for the whole transaction.
      if (state_q inside {SNOOP, C2C0, C2C1, MEM0, MEM1, UPGR}) begin
         ccwait[s_w]      = 1'b1;
         ccinv[s_w]       = inv_q;
         ccsnoopaddr[s_w] = daddr[r_q];
      end

      case (state_q)
         IDLE: begin
            // The grant cycle itself completes nothing.
            if (|dreq_w) begin
               r_d    = (dreq_w == 2'b11) ? dptr_q : dreq_w[1];
               dptr_d = ~r_d;
               inv_d  = cctrans[r_d];
               state_d = dWEN[r_d] ? DWR : SNOOP;
            end else if (|iREN) begin
               r_d     = (iREN == 2'b11) ? iptr_q : iREN[1];
               iptr_d  = ~r_d;
               state_d = IFETCH;
            end
         end
         SNOOP: begin
            if (!live_w)               state_d = IDLE;
            else if (!dREN[r_q])       state_d = UPGR;
            else if (ccwrite[s_w])     state_d = C2C0;
            else                       state_d = MEM0;
         end
         UPGR: begin
            state_d = IDLE;
            if (live_w) dwait[r_q] = 1'b0;
         end
         C2C0, C2C1: begin
            // The dirty word goes to the requester and is written back at once.
            ramWEN      = 1'b1;
            ramaddr     = daddr[r_q];
            ramstore    = dstore[s_w];
            dload[r_q]  = dstore[s_w];
            if (!live_w) state_d = IDLE;
            else if (ram_ready) begin
               dwait   = 2'b00;
               state_d = (state_q == C2C0) ? C2C1 : IDLE;
            end
         end
         MEM0, MEM1: begin
            ramREN     = 1'b1;
            ramaddr    = daddr[r_q];
            dload[r_q] = ramload;
            if (!live_w) state_d = IDLE;
            else if (ram_ready) begin
               dwait[r_q] = 1'b0;
               state_d    = (state_q == MEM0) ? MEM1 : IDLE;
            end
         end
         DWR: begin
            ramWEN   = 1'b1;
            ramaddr  = daddr[r_q];
            ramstore = dstore[r_q];
            if (!live_w) state_d = IDLE;
            else if (ram_ready) begin
               dwait[r_q] = 1'b0;
               state_d    = IDLE;
            end
         end
         IFETCH: begin
            ramREN     = 1'b1;
            ramaddr    = iaddr[r_q];
            iload[r_q] = ramload;
            if (ram_ready) begin
               iwait[r_q] = 1'b0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_coherence_ctrl.sv
// Bench for coherence_ctrl: a memory model with programmable latency, two
// behavioural cores that drop their request after the expected number of
// words, and a scoreboard of expected completions and memory writes.
module tb_coherence_ctrl;

   logic             CLK = 1'b0;
   logic             nRST;
   logic [1:0]       iREN, dREN, dWEN, cctrans, ccwrite;
   logic [1:0][31:0] iaddr, daddr, dstore;
   logic [1:0]       iwait, dwait, ccwait, ccinv;
   logic [1:0][31:0] iload, dload, ccsnoopaddr;
   logic             ramREN, ramWEN, ram_ready;
   logic [31:0]      ramaddr, ramstore, ramload;

   always #5 CLK = ~CLK;

   coherence_ctrl dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .cctrans(cctrans), .ccwrite(ccwrite),
      .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
      .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ram_ready(ram_ready)
   );

   // memory model: fixed contents, ready after lat wait cycles
   function automatic logic [31:0] memval(input logic [31:0] a);
      return (a == 32'h40) ? 32'h1234 : (a ^ 32'hC0DE0000);
   endfunction

   int lat = 0;
   int rcnt = 0;
   assign ramload   = memval(ramaddr);
   assign ram_ready = (ramREN | ramWEN) && (rcnt == lat);
   always @(posedge CLK) rcnt <= (ram_ready || !(ramREN || ramWEN)) ? 0 : rcnt + 1;

   typedef struct { bit isd; int core; logic [31:0] data; bit chk; } exp_t;
   typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
   exp_t sb[$];
   wr_t  wq[$];

   int checks = 0, errors = 0;
   int ileft[2], dleft[2];
   int ramcyc, snp_seen, exp_snp_core;
   logic [31:0] exp_snp;
   logic exp_inv;
   logic [1:0] cw_prev = 2'b00;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic pop_cmp(input bit isd, input int c, input logic [31:0] data);
      exp_t e;
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("FAIL unexpected_done isd=%0d core=%0d act=pulse exp=none @%0t", isd, c, $time);
      end else begin
         e = sb.pop_front();
         chk("sb_kind", 64'(isd), 64'(e.isd));
         chk("sb_core", 64'(c), 64'(e.core));
         if (e.chk) chk("sb_data", 64'(data), 64'(e.data));
      end
   endtask

   // One clock: sample at the falling edge, score, then let the cores react.
   task automatic tick();
      logic [1:0] iw, dw, cw;
      wr_t w;
      @(negedge CLK);
      iw = iwait; dw = dwait; cw = ccwait;
      if (ramREN && ramWEN) begin
         errors++;
         $display("FAIL ram_excl act=both exp=one @%0t", $time);
      end
      if (ramREN || ramWEN) ramcyc++;
      if (ramWEN && ram_ready) begin
         if (wq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write act=%h exp=none", ramaddr);
         end else begin
            w = wq.pop_front();
            chk("wr_addr", 64'(ramaddr), 64'(w.a));
            chk("wr_data", 64'(ramstore), 64'(w.d));
         end
      end
      for (int c = 0; c < 2; c++) begin
         if (cw[c] && !cw_prev[c]) begin
            snp_seen++;
            chk("snp_core", 64'(c), 64'(exp_snp_core));
            chk("snp_addr", 64'(ccsnoopaddr[c]), 64'(exp_snp));
            chk("snp_inv", 64'(ccinv[c]), 64'(exp_inv));
         end
         if (!iw[c]) pop_cmp(1'b0, c, iload[c]);
         if (!dw[c] && cw[c]) chk("c2c_pair", 64'(dw[1-c]), 64'd0);
         else if (!dw[c]) pop_cmp(1'b1, c, dload[c]);
      end
      cw_prev = cw;
      for (int c = 0; c < 2; c++) begin
         if (!iw[c] && iREN[c]) begin
            ileft[c]--;
            if (ileft[c] <= 0) iREN[c] = 1'b0;
         end
         if (!dw[c] && cw[c]) dstore[c] = dstore[c] + 32'h11;
         else if (!dw[c] && (dREN[c] | dWEN[c] | cctrans[c])) begin
            dleft[c]--;
            if (dREN[c]) daddr[c] = daddr[c] + 32'd4;
            if (dWEN[c]) dstore[c] = dstore[c] + 32'd1;
            if (dleft[c] <= 0) begin
               dREN[c] = 1'b0; dWEN[c] = 1'b0; cctrans[c] = 1'b0;
            end
         end
      end
   endtask

   task automatic wait_done(input string name, input int maxc);
      int n = 0;
      while ((sb.size() != 0 || wq.size() != 0 || (|{iREN, dREN, dWEN, cctrans})) && n < maxc) begin
         tick();
         n++;
      end
      checks++;
      if (n >= maxc) begin
         errors++;
         $display("FAIL %s_timeout act=%0d exp<%0d sb=%0d wq=%0d", name, n, maxc, sb.size(), wq.size());
         sb.delete(); wq.delete();
         iREN = 0; dREN = 0; dWEN = 0; cctrans = 0;
      end
      tick(); tick();
   endtask

   // op: 0 ifetch, 1 read, 2 write, 3 upgrade
   typedef struct {
      int core; int op; logic [31:0] addr; logic [31:0] wdat;
      bit ccw; bit rdx; int lat; logic [31:0] exp0; logic [31:0] exp1; bit exp_inv;
   } vec_t;
   vec_t vecs[8];

   initial begin
      vecs[0] = '{0, 0, 32'h40,  32'h0,    1'b0, 1'b0, 2, 32'h1234,     32'h0,        1'b0};
      vecs[1] = '{1, 0, 32'h80,  32'h0,    1'b0, 1'b0, 0, 32'hC0DE0080, 32'h0,        1'b0};
      vecs[2] = '{0, 1, 32'h200, 32'h0,    1'b0, 1'b0, 1, 32'hC0DE0200, 32'hC0DE0204, 1'b0};
      vecs[3] = '{0, 1, 32'h80,  32'hAA,   1'b1, 1'b0, 1, 32'hAA,       32'hBB,       1'b0};
      vecs[4] = '{1, 2, 32'h300, 32'h5555, 1'b0, 1'b0, 3, 32'h0,        32'h0,        1'b0};
      vecs[5] = '{1, 3, 32'h100, 32'h0,    1'b0, 1'b0, 1, 32'h0,        32'h0,        1'b1};
      vecs[6] = '{1, 1, 32'h400, 32'h0,    1'b0, 1'b1, 0, 32'hC0DE0400, 32'hC0DE0404, 1'b1};
      vecs[7] = '{0, 2, 32'h20,  32'hDEAD, 1'b0, 1'b0, 0, 32'h0,        32'h0,        1'b0};

      nRST = 1'b0;
      iREN = 0; dREN = 0; dWEN = 0; cctrans = 0; ccwrite = 0;
      iaddr = '0; daddr = '0; dstore = '0;
      ileft = '{0, 0}; dleft = '{0, 0};
      exp_snp = 0; exp_inv = 0; exp_snp_core = 0; ramcyc = 0; snp_seen = 0;
      #1;
      chk("rst_iwait", 64'(iwait), 64'd3);
      chk("rst_dwait", 64'(dwait), 64'd3);
      chk("rst_ccwait", 64'(ccwait), 64'd0);
      chk("rst_ram", 64'({ramREN, ramWEN}), 64'd0);
      tick(); tick();
      nRST = 1'b1;
      tick();

      // table of single transactions
      for (int i = 0; i < 8; i++) begin
         automatic vec_t v = vecs[i];
         automatic int c = v.core;
         automatic int s = 1 - v.core;
         lat = v.lat; ramcyc = 0; snp_seen = 0;
         exp_snp = v.addr; exp_inv = v.exp_inv; exp_snp_core = s;
         case (v.op)
            0: begin
               iaddr[c] = v.addr; ileft[c] = 1;
               sb.push_back('{1'b0, c, v.exp0, 1'b1});
               iREN[c] = 1'b1;
            end
            1: begin
               daddr[c] = v.addr; dleft[c] = 2;
               sb.push_back('{1'b1, c, v.exp0, 1'b1});
               sb.push_back('{1'b1, c, v.exp1, 1'b1});
               if (v.ccw) begin
                  ccwrite[s] = 1'b1; dstore[s] = v.wdat;
                  wq.push_back('{v.addr, v.exp0});
                  wq.push_back('{v.addr + 32'd4, v.exp1});
               end
               dREN[c] = 1'b1;
               cctrans[c] = v.rdx;
            end
            2: begin
               daddr[c] = v.addr; dstore[c] = v.wdat; dleft[c] = 1;
               sb.push_back('{1'b1, c, 32'h0, 1'b0});
               wq.push_back('{v.addr, v.wdat});
               dWEN[c] = 1'b1;
            end
            default: begin
               daddr[c] = v.addr; dleft[c] = 1;
               sb.push_back('{1'b1, c, 32'h0, 1'b0});
               cctrans[c] = 1'b1;
            end
         endcase
         wait_done($sformatf("vec%0d", i), 60);
         ccwrite = 2'b00;
         chk($sformatf("vec%0d_snoops", i), 64'(snp_seen), (v.op == 1 || v.op == 3) ? 64'd1 : 64'd0);
         if (v.op == 3) chk("upgr_noram", 64'(ramcyc), 64'd0);
      end

      // data beats instruction: core1 read first, then core0 fetch
      lat = 1; snp_seen = 0;
      exp_snp = 32'h500; exp_inv = 1'b0; exp_snp_core = 0;
      iaddr[0] = 32'h44; ileft[0] = 1;
      daddr[1] = 32'h500; dleft[1] = 2;
      sb.push_back('{1'b1, 1, 32'hC0DE0500, 1'b1});
      sb.push_back('{1'b1, 1, 32'hC0DE0504, 1'b1});
      sb.push_back('{1'b0, 0, 32'hC0DE0044, 1'b1});
      iREN[0] = 1'b1; dREN[1] = 1'b1;
      wait_done("prio", 80);
      chk("prio_snoops", 64'(snp_seen), 64'd1);

      // reset during MEM1: immediate reset outputs, no second completion
      begin
         automatic int n = 0;
         lat = 4; exp_snp = 32'h600; exp_inv = 1'b0; exp_snp_core = 1;
         daddr[0] = 32'h600; dleft[0] = 2;
         sb.push_back('{1'b1, 0, 32'hC0DE0600, 1'b1});
         dREN[0] = 1'b1;
         while (sb.size() != 0 && n < 40) begin tick(); n++; end
         chk("mem0_reached", 64'(sb.size()), 64'd0);
         tick();
         #2 nRST = 1'b0;
         #1;
         chk("mrst_dwait", 64'(dwait), 64'd3);
         chk("mrst_iwait", 64'(iwait), 64'd3);
         chk("mrst_cc", 64'({ccwait, ccinv}), 64'd0);
         chk("mrst_snpaddr", 64'(ccsnoopaddr), 64'd0);
         chk("mrst_ram", 64'({ramREN, ramWEN}), 64'd0);
         chk("mrst_ramaddr", 64'(ramaddr), 64'd0);
         chk("mrst_dload", 64'(dload), 64'd0);
         dREN[0] = 1'b0; dleft[0] = 0;
         tick(); tick();
         nRST = 1'b1;
         tick(); tick(); tick();
         chk("mrst_noextra", 64'(sb.size()), 64'd0);
      end

      // both cores write back-to-back: grants alternate 0,1,0,1
      lat = 1; snp_seen = 0;
      daddr[0] = 32'h700; dstore[0] = 32'h10; dleft[0] = 2;
      daddr[1] = 32'h800; dstore[1] = 32'h20; dleft[1] = 2;
      for (int k = 0; k < 2; k++) begin
         sb.push_back('{1'b1, 0, 32'h0, 1'b0});
         sb.push_back('{1'b1, 1, 32'h0, 1'b0});
         wq.push_back('{32'h700, 32'h10 + 32'(k)});
         wq.push_back('{32'h800, 32'h20 + 32'(k)});
      end
      dWEN = 2'b11;
      wait_done("rr", 100);
      chk("rr_snoops", 64'(snp_seen), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
